// File: rtl/apu_pkg.sv
// apu_pkg
// Shared definitions for the APU register sequencer: the sequencer FSM state
// encoding, the register slot that fires a channel trigger, and default widths.
package apu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Writing the last register of a channel (address[1:0] == TRIG_SLOT)
  // tells that channel to start using its new settings.
  localparam logic [1:0] TRIG_SLOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Synchronous DEPTH x WIDTH command FIFO that holds register writes until the
// sequencer can commit them.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (empties the FIFO)
//   push   in   write wdata at the tail; accepted when not full, or when a pop
//                happens on the same edge
//   pop    in   advance the head; ignored when empty
//   wdata  in   entry to push
//   rdata  out  entry at the head
//   count  out  number of valid entries
//   full   out  count == DEPTH
//   empty  out  count == 0
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == FULL_CNT);
  assign count = r_count;
  assign rdata = r_mem[r_head];

  // A pop on the same edge frees the head slot, so a push into a full FIFO
  // is still taken when both happen together.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apu_reg_sequencer.sv
// apu_reg_sequencer
// Buffers register writes decoded by the UART receiver and commits them one at
// a time into the APU register bank. Writing the last register of a channel
// also pulses that channel's trigger for one clock.
//
// State table:
//   IDLE   | waiting for a buffered write with hold low
//   FETCH  | head of FIFO latched into pend_addr/pend_data, FIFO popped
//   COMMIT | pending write lands in the bank, trigger fired if slot 3
//
// Ports:
//   clk         in   system clock (UART shares it)
//   rst         in   asynchronous active-high reset
//   uart_addr   in   decoded register address, valid with uart_ready
//   uart_data   in   decoded register data, valid with uart_ready
//   uart_ready  in   level; rises once per received message
//   hold        in   APU busy; blocks the start of a FETCH
//   reg_bank    out  flattened bank, entry i at [i*DATA_W +: DATA_W]
//   trigger     out  one-cycle pulse per channel
//   busy        out  FIFO non-empty or FSM not idle
//   overflow    out  sticky; a message was dropped on a full FIFO
module apu_reg_sequencer
  import apu_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_W-1:0]               uart_addr,
  input  logic [DATA_W-1:0]               uart_data,
  input  logic                            uart_ready,
  input  logic                            hold,
  output logic [(2**ADDR_W)*DATA_W-1:0]   reg_bank,
  output logic [2**(ADDR_W-2)-1:0]        trigger,
  output logic                            busy,
  output logic                            overflow
);

  localparam int NREG  = 2**ADDR_W;
  localparam int NCH   = 2**(ADDR_W-2);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic              r_ready_d;
  logic              w_push;
  logic              w_pop;
  logic              w_commit;
  logic              w_has_cmd;
  logic [ENT_W-1:0]  w_fifo_rdata;
  logic [PTR_W:0]    w_count;
  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [DATA_W-1:0] r_bank [NREG];
  logic [NCH-1:0]    r_trigger;
  logic              r_overflow;

  // One push per rising edge of the ready level.
  assign w_push = uart_ready & ~r_ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_d <= 1'b0;
    end else begin
      r_ready_d <= uart_ready;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({uart_addr, uart_data}),
    .rdata (w_fifo_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Registered count, so a push on this edge does not extend the burst.
  assign w_has_cmd = (w_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_has_cmd && !hold) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        // hold is deliberately not looked at: a started fetch always commits.
        w_pop        = 1'b1;
        w_next_state = COMMIT;
      end
      COMMIT: begin
        w_commit = 1'b1;
        if (w_has_cmd && !hold) begin
          w_next_state = FETCH;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (w_pop) begin
      {r_pend_addr, r_pend_data} <= w_fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_bank[i] <= '0;
      end
    end else if (w_commit) begin
      r_bank[r_pend_addr] <= r_pend_data;
    end
  end

  // Cleared every cycle, so at most one channel bit is ever set and only for
  // the cycle following the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trigger <= '0;
    end else begin
      r_trigger <= '0;
      if (w_commit && (r_pend_addr[1:0] == TRIG_SLOT)) begin
        r_trigger[r_pend_addr[ADDR_W-1:2]] <= 1'b1;
      end
    end
  end

  // A full FIFO only drops the message when no pop frees a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_bank_out
    assign reg_bank[g*DATA_W +: DATA_W] = r_bank[g];
  end

  assign trigger  = r_trigger;
  assign overflow = r_overflow;
  assign busy     = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_apu_reg_sequencer.sv
// tb_apu_reg_sequencer
// Drives UART-style register writes into apu_reg_sequencer. Every accepted
// write is queued as an expected bank update; a monitor pops the queue each
// time a bank entry changes and checks address, data and trigger.
module tb_apu_reg_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   uart_addr = '0;
  logic [7:0]   uart_data = '0;
  logic         uart_ready = 1'b0;
  logic         hold = 1'b0;
  logic [127:0] reg_bank;
  logic [3:0]   trigger;
  logic         busy;
  logic         overflow;

  apu_reg_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .uart_addr  (uart_addr),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .hold       (hold),
    .reg_bank   (reg_bank),
    .trigger    (trigger),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   trig_count = 0;
  wr_t  sb[$];
  int   commit_cyc[$];
  logic [7:0] shadow [16];
  wr_t  mon_e;
  bit   mon_seen;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bank_at(input int i);
    return reg_bank[i*8 +: 8];
  endfunction

  // Scoreboard monitor: any bank entry that differs from the shadow copy is a
  // commit and must match the oldest outstanding write.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    end else begin
      mon_seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (bank_at(i) !== shadow[i]) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_wr_addr", i, 32'hFFFF);
          end else begin
            mon_e = sb.pop_front();
            check_eq("wr_addr", i, 32'(mon_e.a));
            check_eq("wr_data", 32'(bank_at(i)), 32'(mon_e.d));
            check_eq("wr_trig", 32'(trigger),
                     (mon_e.a[1:0] == 2'b11) ? (32'd1 << mon_e.a[3:2]) : 32'd0);
          end
          shadow[i] = bank_at(i);
          mon_seen = 1'b1;
          commit_cyc.push_back(cyc);
        end
      end
      if (!mon_seen && trigger != 4'h0) check_eq("spurious_trig", 32'(trigger), 32'd0);
      if (trigger != 4'h0) trig_count++;
    end
  end

  // Called at a negedge; one message takes two clocks.
  task automatic send_msg(input logic [3:0] a, input logic [7:0] d, input bit expect_commit);
    uart_addr  = a;
    uart_data  = d;
    uart_ready = 1'b1;
    if (expect_commit) sb.push_back('{a: a, d: d});
    @(negedge clk);
    uart_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_bank", 32'(reg_bank == '0), 32'd1);
    check_eq("rst_trig", 32'(trigger), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write: latency 3 from the sampling edge, no trigger.
    uart_addr = 4'd5; uart_data = 8'hA7; uart_ready = 1'b1;
    sb.push_back('{a: 4'd5, d: 8'hA7});
    @(posedge clk);               // k
    @(posedge clk); #1;           // k+1
    uart_ready = 1'b0;
    @(posedge clk); #1;           // k+2
    check_eq("single_early", 32'(bank_at(5)), 32'd0);
    @(posedge clk); #1;           // k+3
    check_eq("single_data", 32'(bank_at(5)), 32'hA7);
    check_eq("single_trig", 32'(trigger), 32'd0);
    @(posedge clk); #1;           // k+4
    check_eq("single_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Trigger write to channel 2, slot 3.
    uart_addr = 4'hB; uart_data = 8'h3C; uart_ready = 1'b1;
    sb.push_back('{a: 4'hB, d: 8'h3C});
    @(posedge clk);
    @(posedge clk); #1;
    uart_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("trig_early", 32'(trigger), 32'd0);
    @(posedge clk); #1;
    check_eq("trig_data", 32'(bank_at(11)), 32'h3C);
    check_eq("trig_pulse", 32'(trigger), 32'h4);
    @(posedge clk); #1;
    check_eq("trig_oneclk", 32'(trigger), 32'd0);
    repeat (2) @(negedge clk);

    // Full FIFO with a push landing on the same edge as the FETCH pop.
    do_reset();
    hold = 1'b1;
    send_msg(4'd8,  8'h21, 1'b1);
    send_msg(4'd9,  8'h22, 1'b1);
    send_msg(4'd10, 8'h23, 1'b1);
    send_msg(4'd13, 8'h24, 1'b1);
    check_eq("pp_held", 32'(bank_at(8)), 32'd0);
    check_eq("pp_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    @(negedge clk);
    send_msg(4'd14, 8'h25, 1'b1);
    check_eq("pp_ovf", 32'(overflow), 32'd0);
    wait_idle("pp_idle");
    check_eq("pp_drain", sb.size(), 32'd0);
    check_eq("pp_last", 32'(bank_at(14)), 32'h25);

    // Level-held ready produces exactly one commit (addr 7 triggers ch1).
    trig_count = 0;
    uart_addr = 4'd7; uart_data = 8'h5A; uart_ready = 1'b1;
    sb.push_back('{a: 4'd7, d: 8'h5A});
    repeat (50) @(negedge clk);
    uart_ready = 1'b0;
    wait_idle("lvl_idle");
    check_eq("lvl_commits", trig_count, 32'd1);
    check_eq("lvl_data", 32'(bank_at(7)), 32'h5A);

    // Reset asserted during COMMIT drops the pending write.
    uart_addr = 4'd2; uart_data = 8'h66; uart_ready = 1'b1;
    @(posedge clk);               // k
    @(posedge clk); #1;           // k+1
    uart_ready = 1'b0;
    @(posedge clk); #1;           // k+2: now in COMMIT
    rst = 1'b1;
    #1;
    check_eq("mid_bank", 32'(reg_bank == '0), 32'd1);
    check_eq("mid_trig", 32'(trigger), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_ovf", 32'(overflow), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_lost", 32'(bank_at(2)), 32'd0);
    check_eq("mid_quiet", 32'(busy), 32'd0);
    send_msg(4'd6, 8'h77, 1'b1);
    wait_idle("mid_idle");
    check_eq("mid_new", 32'(bank_at(6)), 32'h77);

    // Hold with five messages: the fifth overflows, four commit 2 clocks apart.
    hold = 1'b1;
    commit_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      send_msg(4'(i), 8'(i + 1), i < 4);
      if (i == 3) check_eq("ovf_before", 32'(overflow), 32'd0);
    end
    check_eq("ovf_set", 32'(overflow), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("hold_block", 32'(bank_at(0)), 32'd0);
    check_eq("hold_busy", 32'(busy), 32'd1);
    hold = 1'b0;
    wait_idle("hold_idle");
    check_eq("hold_ncommit", commit_cyc.size(), 32'd4);
    for (int i = 1; i < commit_cyc.size(); i++) begin
      check_eq("hold_spacing", commit_cyc[i] - commit_cyc[i-1], 32'd2);
    end
    check_eq("hold_addr4", 32'(bank_at(4)), 32'd0);
    check_eq("hold_addr3", 32'(bank_at(3)), 32'd4);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    check_eq("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
